pipe_stage_skid: RTL and testbench

- Parametrised, elastic successor to the fixed ID/EX-style pipeline register.
- Carries a generic control bundle plus a data payload across one stage, with a valid/ready handshake, a global stall enable, and a synchronous flush (CLR).
- Includes an optional skid entry, so upstream ready is registered, and a saturating counter of squashed instructions.
- Instantiated between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB).

---
 rtl/pipe_stage_skid.sv | 134 +++++++++++++
 tb/tb_pipe_stage_skid.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: elastic pipeline register carrying a control bundle and a data payload.
// Latency: an entry accepted at a clock edge appears on out_* right after that edge (1 cycle).
// Backpressure: with SKID=1 a second entry absorbs one stall and in_ready is registered.
//               With SKID=0 in_ready is combinational from out_ready/EN.
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   CLR                 - synchronous flush of all held entries (counted in flush_count)
//   EN                  - stage enable; 0 stalls both accept and drain
//   in_valid/in_ready   - upstream handshake with in_ctrl/in_data
//   out_valid/out_ready - downstream handshake with out_ctrl/out_data
//   flush_count         - saturating count of valid entries discarded by CLR
module pipe_stage_skid #(
  parameter int DATA_WIDTH  = 32,
  parameter int CTRL_WIDTH  = 12,
  parameter int SKID        = 1,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   CLR,
  input  logic                   EN,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [CTRL_WIDTH-1:0]  in_ctrl,
  input  logic [DATA_WIDTH-1:0]  in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [CTRL_WIDTH-1:0]  out_ctrl,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic [COUNT_WIDTH-1:0] flush_count
);

  logic                  main_valid;
  logic [CTRL_WIDTH-1:0] main_ctrl;
  logic [DATA_WIDTH-1:0] main_data;

  logic                  skid_valid;
  logic [CTRL_WIDTH-1:0] skid_ctrl;
  logic [DATA_WIDTH-1:0] skid_data;

  logic acc;
  logic drn;
  logic main_free;

  assign drn       = main_valid & out_ready & EN;
  assign acc       = in_valid & in_ready & EN;
  // Main can take a new entry this edge if it is empty or its entry leaves.
  assign main_free = !main_valid | drn;

  // Main register: the skid entry always has priority over new input,
  // which keeps the stream in order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid <= 1'b0;
      main_ctrl  <= '0;
      main_data  <= '0;
    end else if (CLR) begin
      main_valid <= 1'b0;
      main_ctrl  <= '0;
      main_data  <= '0;
    end else if (main_free) begin
      if (skid_valid) begin
        main_valid <= 1'b1;
        main_ctrl  <= skid_ctrl;
        main_data  <= skid_data;
      end else if (acc) begin
        main_valid <= 1'b1;
        main_ctrl  <= in_ctrl;
        main_data  <= in_data;
      end else begin
        // Payload is kept on a bubble; only valid drops.
        main_valid <= 1'b0;
      end
    end
  end

  generate
    if (SKID != 0) begin : g_skid
      logic skid_cap;

      // Capture when main stays occupied, or when main is busy taking the
      // older skid entry on this same edge.
      assign skid_cap = acc & ((main_valid & !drn) | (main_free & skid_valid));

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          skid_valid <= 1'b0;
          skid_ctrl  <= '0;
          skid_data  <= '0;
        end else if (CLR) begin
          skid_valid <= 1'b0;
          skid_ctrl  <= '0;
          skid_data  <= '0;
        end else if (skid_cap) begin
          skid_valid <= 1'b1;
          skid_ctrl  <= in_ctrl;
          skid_data  <= in_data;
        end else if (skid_valid && main_free) begin
          skid_valid <= 1'b0;
        end
      end

      // Straight from a flop: upstream never sees a path from out_ready.
      assign in_ready = !skid_valid;
    end else begin : g_noskid
      assign skid_valid = 1'b0;
      assign skid_ctrl  = '0;
      assign skid_data  = '0;
      assign in_ready   = !main_valid | (out_ready & EN);
    end
  endgenerate

  // Flush accounting: add the number of valid entries being discarded,
  // clamped at all-ones. One extra bit is enough since at most 2 are added.
  logic [1:0]             flush_n;
  logic [COUNT_WIDTH:0]   flush_sum;

  assign flush_n   = {1'b0, main_valid} + {1'b0, skid_valid};
  assign flush_sum = {1'b0, flush_count} + (COUNT_WIDTH+1)'(flush_n);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush_count <= '0;
    end else if (CLR) begin
      flush_count <= flush_sum[COUNT_WIDTH] ? '1 : flush_sum[COUNT_WIDTH-1:0];
    end
  end

  assign out_valid = main_valid;
  // Bubbles carry zero control so no write enables leak downstream.
  assign out_ctrl  = main_valid ? main_ctrl : '0;
  assign out_data  = main_data;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench: u_skid (SKID=1, COUNT_WIDTH=2) and u_flat (SKID=0) share all inputs.
module tb_pipe_stage_skid;

  logic        clk = 1'b0;
  logic        rst;
  logic        CLR;
  logic        EN;
  logic        in_valid;
  logic        out_ready;
  logic [11:0] in_ctrl;
  logic [31:0] in_data;

  logic        s_in_ready, s_out_valid;
  logic [11:0] s_out_ctrl;
  logic [31:0] s_out_data;
  logic [1:0]  s_flush_count;

  logic        f_in_ready, f_out_valid;
  logic [11:0] f_out_ctrl;
  logic [31:0] f_out_data;
  logic [7:0]  f_flush_count;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  pipe_stage_skid #(.DATA_WIDTH(32), .CTRL_WIDTH(12), .SKID(1), .COUNT_WIDTH(2)) u_skid (
    .clk(clk), .rst(rst), .CLR(CLR), .EN(EN),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_ctrl(s_out_ctrl),
    .out_data(s_out_data), .flush_count(s_flush_count)
  );

  pipe_stage_skid #(.DATA_WIDTH(32), .CTRL_WIDTH(12), .SKID(0), .COUNT_WIDTH(8)) u_flat (
    .clk(clk), .rst(rst), .CLR(CLR), .EN(EN),
    .in_valid(in_valid), .in_ready(f_in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(f_out_valid), .out_ready(out_ready), .out_ctrl(f_out_ctrl),
    .out_data(f_out_data), .flush_count(f_flush_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [11:0] c, input logic [31:0] d);
    in_valid = v;
    in_ctrl  = c;
    in_data  = d;
  endtask

  // Fill both entries of u_skid, then flush with a live input present.
  task automatic full_flush();
    out_ready = 1'b0;
    drive(1'b1, 12'h0A1, 32'hA);
    tick();
    drive(1'b1, 12'h0B2, 32'hB);
    tick();
    check("full_in_ready", 32'(s_in_ready), 32'd0);
    CLR = 1'b1;
    drive(1'b1, 12'h0C3, 32'hC);
    tick();
    CLR = 1'b0;
    drive(1'b0, 12'h0, 32'h0);
  endtask

  initial begin
    rst = 1'b1; CLR = 1'b0; EN = 1'b1; out_ready = 1'b0;
    drive(1'b0, 12'h0, 32'h0);
    #2;
    check("rst_out_valid",   32'(s_out_valid),   32'd0);
    check("rst_out_ctrl",    32'(s_out_ctrl),    32'd0);
    check("rst_out_data",    s_out_data,         32'd0);
    check("rst_in_ready",    32'(s_in_ready),    32'd1);
    check("rst_flush_count", 32'(s_flush_count), 32'd0);
    check("rst_flat_ready",  32'(f_in_ready),    32'd1);
    #10 rst = 1'b0;

    // Single transfer, 1-cycle latency.
    tick();
    out_ready = 1'b1;
    drive(1'b1, 12'h0A5, 32'h1234_5678);
    tick();
    check("t1_out_valid", 32'(s_out_valid), 32'd1);
    check("t1_out_ctrl",  32'(s_out_ctrl),  32'h0A5);
    check("t1_out_data",  s_out_data,       32'h1234_5678);
    check("t1_in_ready",  32'(s_in_ready),  32'd1);
    check("t1_flush",     32'(s_flush_count), 32'd0);
    drive(1'b0, 12'h0, 32'h0);
    tick();
    check("bubble_valid", 32'(s_out_valid), 32'd0);
    check("bubble_ctrl",  32'(s_out_ctrl),  32'd0);
    check("bubble_data",  s_out_data,       32'h1234_5678);

    // Back-to-back with downstream stalled: D0 main, D1 skid, D2 held upstream.
    out_ready = 1'b0;
    drive(1'b1, 12'h001, 32'd1);
    tick();
    check("b2b_ready_1", 32'(s_in_ready), 32'd1);
    drive(1'b1, 12'h002, 32'd2);
    tick();
    check("b2b_ready_2", 32'(s_in_ready), 32'd0);
    check("b2b_main_d0", s_out_data,      32'd1);
    drive(1'b1, 12'h003, 32'd3);
    tick();
    check("b2b_hold_d0", s_out_data,      32'd1);
    check("b2b_ready_3", 32'(s_in_ready), 32'd0);
    out_ready = 1'b1;
    tick();
    check("drain_d1",       s_out_data,       32'd2);
    check("drain_d1_ctrl",  32'(s_out_ctrl),  32'h002);
    check("drain_ready_up", 32'(s_in_ready),  32'd1);
    tick();
    check("drain_d2",       s_out_data,       32'd3);
    check("drain_d2_valid", 32'(s_out_valid), 32'd1);
    drive(1'b0, 12'h0, 32'h0);
    tick();
    check("drain_empty",    32'(s_out_valid), 32'd0);

    // Stall: EN=0 holds everything for 4 cycles.
    out_ready = 1'b0;
    drive(1'b1, 12'h0DE, 32'hDEAD);
    tick();
    EN = 1'b0;
    out_ready = 1'b1;
    drive(1'b1, 12'h0BE, 32'hBEEF);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("stall_data",  s_out_data,       32'hDEAD);
      check("stall_valid", 32'(s_out_valid), 32'd1);
    end
    check("stall_ready", 32'(s_in_ready), 32'd1);
    EN = 1'b1;
    tick();
    check("resume_1", s_out_data, 32'hBEEF);
    drive(1'b1, 12'h0CA, 32'hCAFE);
    tick();
    check("resume_2", s_out_data, 32'hCAFE);
    drive(1'b0, 12'h0, 32'h0);
    tick();
    check("resume_empty", 32'(s_out_valid), 32'd0);

    // Flush with both entries full and an input on the same edge.
    full_flush();
    check("flush_valid",  32'(s_out_valid),   32'd0);
    check("flush_ctrl",   32'(s_out_ctrl),    32'd0);
    check("flush_data",   s_out_data,         32'd0);
    check("flush_ready",  32'(s_in_ready),    32'd1);
    check("flush_count",  32'(s_flush_count), 32'd2);
    tick();
    check("flush_dropped", 32'(s_out_valid),  32'd0);

    // Saturation at 2^2-1.
    full_flush();
    check("sat_count_2", 32'(s_flush_count), 32'd3);
    full_flush();
    check("sat_count_3", 32'(s_flush_count), 32'd3);

    // SKID=0: combinational in_ready and full throughput.
    out_ready = 1'b1;
    drive(1'b1, 12'h010, 32'h10);
    tick();
    check("flat_main",     f_out_data,        32'h10);
    check("flat_ready_hi", 32'(f_in_ready),   32'd1);
    out_ready = 1'b0;
    #1;
    check("flat_ready_lo", 32'(f_in_ready),   32'd0);
    out_ready = 1'b1;
    #1;
    check("flat_ready_re", 32'(f_in_ready),   32'd1);
    drive(1'b1, 12'h011, 32'h11);
    tick();
    check("flat_tp_1", f_out_data, 32'h11);
    drive(1'b1, 12'h012, 32'h12);
    tick();
    check("flat_tp_2",       f_out_data,        32'h12);
    check("flat_tp_2_ctrl",  32'(f_out_ctrl),   32'h012);

    // Async reset mid-stream acts before the next edge.
    #2 rst = 1'b1;
    #1;
    check("arst_flat_valid", 32'(f_out_valid),   32'd0);
    check("arst_flat_ctrl",  32'(f_out_ctrl),    32'd0);
    check("arst_skid_valid", 32'(s_out_valid),   32'd0);
    check("arst_skid_count", 32'(s_flush_count), 32'd0);
    #10 rst = 1'b0;
    drive(1'b0, 12'h0, 32'h0);
    tick();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
